charlie7x5_scan: RTL

CHARLIE7X5_SCAN -- requirements
Module: charlie7x5_scan

---
 rtl/charlie7x5_scan.sv | 132 +++++++++++++
 1 files changed

// File: rtl/charlie7x5_scan.sv
// rtl/charlie7x5_scan.sv - 7-pin charlieplexed 7x5 LED matrix scanner
//
// Purpose:
//   Scans a 35-pixel charlieplexed display through seven tri-state pins.
//   Each anode phase a (0..6) is preceded by an all-off blank interval.
//   During the drive interval, pin a is driven high. The five following
//   pins (a+1..a+5 mod 7) are pulled low when their pixel is lit, and
//   are left floating otherwise. Frames are double-buffered: a producer
//   loads a shadow buffer, and the shadow is copied into the displayed
//   buffer only at a frame boundary.
//
// Ports:
//   clock          in   single clock
//   reset_n        in   asynchronous active-low reset
//   frame_valid    in   frame_data holds a new frame
//   frame_ready    out  shadow buffer can accept a frame
//   frame_data     in   35 pixels, pixel p = 5*a + k, 1 = lit
//   charlie7x5_oe  out  per-pin output enable
//   charlie7x5_o   out  per-pin output level
//   frame_sync     out  one-cycle pulse on the last drive cycle of phase 6

module charlie7x5_scan #(
  parameter int TICKS_PER_ROW = 4800,
  parameter int BLANK_TICKS   = 16
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        frame_valid,
  output logic        frame_ready,
  input  logic [34:0] frame_data,
  output logic [6:0]  charlie7x5_oe,
  output logic [6:0]  charlie7x5_o,
  output logic        frame_sync
);

  localparam int MAXT = (TICKS_PER_ROW > BLANK_TICKS) ? TICKS_PER_ROW : BLANK_TICKS;
  localparam int CW   = (MAXT > 1) ? $clog2(MAXT) : 1;

  typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

  state_t         state, state_n;
  logic [2:0]     phase, phase_n;
  logic [CW-1:0]  tick, tick_n;

  logic [34:0]    active;
  logic [34:0]    shadow;
  logic           pending;

  logic [6:0]     oe_d, o_d;
  logic           sync_d;
  logic [34:0]    act_sh;
  logic [6:0]     rel_oe;
  logic [13:0]    rot;

  assign frame_ready = ~pending;

  // The drive pattern is built relative to the anode:
  //   bit 0     = the anode itself
  //   bits 1..5 = the five cathodes of this phase
  //   bit 6     = the unused pin, held off
  // Rotating this pattern left by the phase places it on the physical pins.
  always_comb begin
    state_n = state;
    phase_n = phase;
    tick_n  = tick + CW'(1);
    oe_d    = '0;
    o_d     = '0;
    sync_d  = 1'b0;
    act_sh  = active >> (6'd5 * {3'd0, phase});
    rel_oe  = {1'b0, act_sh[4:0], 1'b1};
    rot     = {rel_oe, rel_oe} << phase;
    case (state)
      ST_BLANK: begin
        if (tick == CW'(BLANK_TICKS - 1)) begin
          state_n = ST_DRIVE;
          tick_n  = '0;
        end
      end
      ST_DRIVE: begin
        oe_d = rot[13:7];
        o_d  = 7'b1 << phase;
        if (tick == CW'(TICKS_PER_ROW - 1)) begin
          state_n = ST_BLANK;
          tick_n  = '0;
          phase_n = (phase == 3'd6) ? 3'd0 : phase + 3'd1;
          sync_d  = (phase == 3'd6);
        end
      end
      default: ;
    endcase
  end

  // Outputs are registered from the current state. The pins therefore
  // show a given state one cycle after the scan counters enter it, which
  // keeps the pins glitch-free.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= ST_BLANK;
      phase         <= 3'd0;
      tick          <= '0;
      charlie7x5_oe <= '0;
      charlie7x5_o  <= '0;
      frame_sync    <= 1'b0;
    end else begin
      state         <= state_n;
      phase         <= phase_n;
      tick          <= tick_n;
      charlie7x5_oe <= oe_d;
      charlie7x5_o  <= o_d;
      frame_sync    <= sync_d;
    end
  end

  // The swap happens on the edge that ends the frame_sync cycle, which is
  // also the first (blank) cycle of the next frame. The displayed buffer
  // therefore never changes while a drive cycle is using it. A swap and an
  // accept cannot coincide, because an accept needs pending to be clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      active  <= '0;
      shadow  <= '0;
      pending <= 1'b0;
    end else if (frame_sync && pending) begin
      active  <= shadow;
      pending <= 1'b0;
    end else if (frame_valid && !pending) begin
      shadow  <= frame_data;
      pending <= 1'b1;
    end
  end

endmodule
